fft_acc_nios2_gen2_0_cpu_debug_ocimem_ctrl: RTL and testbench
=============================================================

# fft_acc_nios2_gen2_0_cpu_debug_ocimem_ctrl

Downstream consumer of the debug slave's system-clock outputs (`jdo`, `take_action_ocimem_a/b`, `take_no_action_ocimem_a`). Owns the single-port on-chip debug RAM: it executes JTAG address-load, read and write commands, and returns read data on `MonDReg`. It also serves the CPU's debug-memory Avalon slave port. The JTAG side always has priority, and CPU transfers are stalled with `waitrequest`.

## Interface
- `ADDR_W`, 8: RAM word-address width; depth is 2^ADDR_W × 32 bit; legal range 4..9.
- `clk`  in  1: system clock; the only clock.
- `reset`  in  1: reset is synchronous and active-high.
- `jdo`  in  38: JTAG data word from the debug slave; stable while any take_* pulse is high.
- `take_action_ocimem_a`  in  1: 1-cycle pulse; address load, optional read.
- `take_no_action_ocimem_a`  in  1: 1-cycle pulse; read at current address.
- `take_action_ocimem_b`  in  1: 1-cycle pulse; write at current address.
- `address`  in  ADDR_W: CPU word address.
- `read`, `write`  in  1: CPU Avalon strobes; never both high.
- `writedata`  in  32: CPU write data.
- `byteenable`  in  4: CPU byte enables.
- `debugaccess`  in  1: CPU access permitted only when high.
- `readdata`  out  32: CPU read data; valid when `read` is high and `waitrequest` is low.
- `waitrequest`  out  1: combinational stall.
- `MonDReg`  out  32: last JTAG read result.
- `MonAReg`  out  ADDR_W: current JTAG word address.
- `jtag_overrun`  out  1: sticky; a JTAG command was dropped.

## Operation
- JTAG command decode, one command per pulse:
  - **Cmd A** (`take_action_ocimem_a`): `MonAReg` <= `jdo[ADDR_W+25:26]`. If `jdo[35]` = 1, also read at the new address.
  - **Cmd N** (`take_no_action_ocimem_a`): read at `MonAReg`.
  - **Cmd B** (`take_action_ocimem_b`): write `jdo[34:3]` to `RAM[MonAReg]`, all four bytes.
- Every JTAG read or write post-increments `MonAReg` modulo 2^ADDR_W. All-ones wraps to 0. A Cmd A without read does not increment.
- State machine: IDLE, J_RD, J_LAT, C_RD, C_DONE.
  - IDLE, Cmd B: write RAM at the edge, increment; stay IDLE.
  - IDLE, Cmd A (no read): load address; stay IDLE.
  - IDLE, read command → J_RD: RAM address = `MonAReg`.
  - J_RD → J_LAT.
  - J_LAT: `MonDReg` <= RAM q; increment; → IDLE.
  - IDLE, CPU read with no JTAG work → C_RD → C_DONE. In C_DONE, `readdata` = RAM q, or 0 when `debugaccess` was low at acceptance. → IDLE.
  - IDLE, CPU write with no JTAG work: if `debugaccess` is high, write bytes per `byteenable` at that edge; otherwise drop. Completes in that cycle.
- Priority in IDLE: pending JTAG > new JTAG > CPU.
- Pending slot, one deep, holds command type and `jdo` copy:
  - A command arriving when not in IDLE is latched into the slot.
  - If the slot is full, the new command is dropped and `jtag_overrun` <= 1.
  - In IDLE with the slot full and a new command in the same cycle: service the slot and latch the new command into it (no overrun).
- `waitrequest` = (`read` | `write`) & !(C_DONE & `read`) & !(IDLE & `write` & no pending & no JTAG pulse).
- CPU `address`, `writedata` and `byteenable` are held by the master while stalled; the block does not register them.
- Reset values: state IDLE; `MonAReg` 0; `MonDReg` 0; `readdata` 0; `jtag_overrun` 0; pending slot empty. RAM contents are not reset.
- Reset mid-operation: any in-flight JTAG read or CPU read is abandoned with no `MonDReg` update. The CPU master sees `waitrequest` cleared only after re-issue.

## Timing
- JTAG write: RAM updated at the pulse edge; `MonAReg` + 1 visible the next cycle.
- JTAG read: pulse at cycle T in IDLE; `MonDReg` valid from T+3, with `MonAReg` incremented in the same cycle.
- CPU read accepted at T: `waitrequest` high at T and T+1, low at T+2 with data; a new request is accepted at T+3.
- CPU write with no contention: zero-wait.
- Pending JTAG commands start at most 3 cycles after arrival.

## Test plan
- After reset: Cmd A with `jdo[33:26]`=0x10 and `jdo[35]`=0, then Cmd B with data 0xCAFEF00D → `RAM[0x10]` = 0xCAFEF00D and `MonAReg` = 0x11.
- Cmd A with address 0x10 and `jdo[35]`=1 → `MonDReg` = 0xCAFEF00D at T+3 and `MonAReg` = 0x11; then Cmd N → reads `RAM[0x11]` and `MonAReg` = 0x12.
- Cmd A to 0xFF, then Cmd B → `MonAReg` wraps to 0x00.
- CPU write to 0x20, `byteenable`=0b0011, `writedata`=0x12345678 over 0xFFFFFFFF → reads back 0xFFFF5678 with `waitrequest` high for exactly 2 cycles. With `debugaccess`=0: write ignored and read returns 0.
- Three JTAG commands issued 1 cycle apart starting in J_RD → first latched in the pending slot, second dropped, `jtag_overrun` = 1. A CPU read asserted throughout stalls until JTAG work drains.
- Assert `reset` in J_RD → next cycle IDLE, `MonDReg` = 0, `MonAReg` = 0, `jtag_overrun` = 0; RAM data preserved.

Source files
------------

// File: rtl/fft_acc_nios2_gen2_0_cpu_debug_ocimem_ctrl_if.sv
// CPU-side Avalon debug-memory slave bus of the OCI memory controller.
interface fft_acc_nios2_gen2_0_cpu_debug_ocimem_ctrl_if #(
  parameter int ADDR_W = 8
) ();
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic              debugaccess;
  logic [31:0]       readdata;
  logic              waitrequest;

  modport master (
    output address, read, write, writedata, byteenable, debugaccess,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, read, write, writedata, byteenable, debugaccess,
    output readdata, waitrequest
  );
endinterface

// File: rtl/fft_acc_nios2_gen2_0_cpu_debug_ocimem_ctrl.sv
// OCI debug RAM controller: executes JTAG address-load/read/write commands
// with priority over the CPU debug-memory Avalon port, which is stalled via
// waitrequest. JTAG commands arriving while busy park in a one-deep slot.
module fft_acc_nios2_gen2_0_cpu_debug_ocimem_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [37:0]         jdo,
  input  logic                take_action_ocimem_a,
  input  logic                take_no_action_ocimem_a,
  input  logic                take_action_ocimem_b,
  fft_acc_nios2_gen2_0_cpu_debug_ocimem_ctrl_if.slave bus,
  output logic [31:0]         MonDReg,
  output logic [ADDR_W-1:0]   MonAReg,
  output logic                jtag_overrun
);

  typedef enum logic [2:0] {IDLE, J_RD, J_LAT, C_RD, C_DONE} state_t;
  typedef enum logic [1:0] {CMD_A, CMD_N, CMD_B} cmd_t;

  state_t            state_reg;
  logic              pend_valid_reg;
  cmd_t              pend_cmd_reg;
  logic [37:0]       pend_jdo_reg;
  logic              cpu_ok_reg;
  logic [31:0]       readdata_reg;
  logic [31:0]       mon_d_reg;
  logic [ADDR_W-1:0] mon_a_reg;
  logic              overrun_reg;

  logic [31:0]       mem [2**ADDR_W];
  logic [31:0]       ram_q;

  logic              new_cmd;
  cmd_t              new_type;
  logic              in_idle;
  logic              svc_valid;
  cmd_t              svc_type;
  logic [37:0]       svc_jdo;
  logic              svc_read;
  logic              jtag_wr;
  logic              cpu_free;
  logic              cpu_wr;
  logic              cpu_rd_accept;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              unused_jdo;

  // A parked command always goes before a freshly arriving one.
  assign new_cmd   = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign new_type  = take_action_ocimem_a ? CMD_A : (take_no_action_ocimem_a ? CMD_N : CMD_B);
  assign in_idle   = (state_reg == IDLE);
  assign svc_valid = in_idle & (pend_valid_reg | new_cmd);
  assign svc_type  = pend_valid_reg ? pend_cmd_reg : new_type;
  assign svc_jdo   = pend_valid_reg ? pend_jdo_reg : jdo;
  assign svc_read  = svc_valid & (((svc_type == CMD_A) & svc_jdo[35]) | (svc_type == CMD_N));
  assign jtag_wr   = svc_valid & (svc_type == CMD_B);
  assign unused_jdo = ^{svc_jdo[37:36], svc_jdo[2:0]};

  // The CPU only gets the RAM when no JTAG work exists this cycle.
  assign cpu_free      = in_idle & ~pend_valid_reg & ~new_cmd;
  assign cpu_wr        = cpu_free & bus.write & bus.debugaccess;
  assign cpu_rd_accept = cpu_free & bus.read;

  assign ram_we    = jtag_wr | cpu_wr;
  assign ram_be    = jtag_wr ? 4'hF : bus.byteenable;
  assign ram_wdata = jtag_wr ? svc_jdo[34:3] : bus.writedata;
  // CPU address is the default so a read accepted in IDLE is fetched at once.
  assign ram_addr  = ((state_reg == J_RD) || jtag_wr) ? mon_a_reg : bus.address;

  assign bus.waitrequest = (bus.read | bus.write)
                         & ~((state_reg == C_DONE) & bus.read)
                         & ~(cpu_free & bus.write);
  assign bus.readdata    = readdata_reg;
  assign MonDReg         = mon_d_reg;
  assign MonAReg         = mon_a_reg;
  assign jtag_overrun    = overrun_reg;

  // Single-port debug RAM with per-byte write enables and registered read.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_we && ram_be[b]) begin
        mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
    ram_q <= mem[ram_addr];
  end

  // Command sequencer, pending slot and monitor registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      pend_valid_reg <= 1'b0;
      pend_cmd_reg   <= CMD_A;
      pend_jdo_reg   <= '0;
      cpu_ok_reg     <= 1'b0;
      readdata_reg   <= '0;
      mon_d_reg      <= '0;
      mon_a_reg      <= '0;
      overrun_reg    <= 1'b0;
    end else begin
      // In IDLE the slot drains; a simultaneous new command refills it.
      if (in_idle) begin
        if (pend_valid_reg && new_cmd) begin
          pend_cmd_reg <= new_type;
          pend_jdo_reg <= jdo;
        end else if (pend_valid_reg) begin
          pend_valid_reg <= 1'b0;
        end
      end else if (new_cmd) begin
        if (!pend_valid_reg) begin
          pend_valid_reg <= 1'b1;
          pend_cmd_reg   <= new_type;
          pend_jdo_reg   <= jdo;
        end else begin
          overrun_reg <= 1'b1;
        end
      end

      case (state_reg)
        IDLE: begin
          if (svc_valid) begin
            if (svc_type == CMD_A) mon_a_reg <= svc_jdo[ADDR_W+25:26];
            if (jtag_wr)           mon_a_reg <= mon_a_reg + ADDR_W'(1);
            if (svc_read)          state_reg <= J_RD;
          end else if (cpu_rd_accept) begin
            cpu_ok_reg <= bus.debugaccess;
            state_reg  <= C_RD;
          end
        end
        J_RD:  state_reg <= J_LAT;
        J_LAT: begin
          mon_d_reg <= ram_q;
          mon_a_reg <= mon_a_reg + ADDR_W'(1);
          state_reg <= IDLE;
        end
        C_RD: begin
          readdata_reg <= cpu_ok_reg ? ram_q : 32'd0;
          state_reg    <= C_DONE;
        end
        C_DONE:  state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_acc_nios2_gen2_0_cpu_debug_ocimem_ctrl.sv
// Randomised scoreboard bench for the OCI debug RAM controller.
module tb_fft_acc_nios2_gen2_0_cpu_debug_ocimem_ctrl;
  localparam int AW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [37:0]   jdo = '0;
  logic          take_a = 1'b0, take_n = 1'b0, take_b = 1'b0;
  logic [31:0]   mon_d;
  logic [AW-1:0] mon_a;
  logic          ovr;

  fft_acc_nios2_gen2_0_cpu_debug_ocimem_ctrl_if #(.ADDR_W(AW)) avl ();

  fft_acc_nios2_gen2_0_cpu_debug_ocimem_ctrl #(.ADDR_W(AW)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_a),
    .take_no_action_ocimem_a (take_n),
    .take_action_ocimem_b    (take_b),
    .bus                     (avl),
    .MonDReg                 (mon_d),
    .MonAReg                 (mon_a),
    .jtag_overrun            (ovr)
  );

  always #5 clk = ~clk;

  // Reference model: memory image and monitor registers, updated as commands issue.
  logic [31:0]   m_mem [DEPTH];
  logic [AW-1:0] m_areg = '0;
  logic [31:0]   m_dreg = '0;
  logic          m_ovr  = 1'b0;
  logic [31:0]   exp_q [$];
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every completed CPU read is compared with the oldest expectation.
  always @(negedge clk) begin
    if (!reset && avl.read && !avl.waitrequest) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL cpu_unexpected_read: got %h expected no completion", avl.readdata);
      end else begin
        check("cpu_readdata", avl.readdata, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] jdo_a(input logic [AW-1:0] a, input logic rd);
    logic [37:0] d;
    d = '0;
    d[AW+25:26] = a;
    d[35] = rd;
    return d;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] data);
    logic [37:0] d;
    d = '0;
    d[34:3] = data;
    return d;
  endfunction

  // kind: 0 = Cmd A, 1 = Cmd N, 2 = Cmd B; one-cycle pulse.
  task automatic jtag(input int kind, input logic [37:0] d);
    jdo = d;
    take_a = (kind == 0);
    take_n = (kind == 1);
    take_b = (kind == 2);
    tick();
    take_a = 1'b0;
    take_n = 1'b0;
    take_b = 1'b0;
  endtask

  task automatic j_load(input logic [AW-1:0] a);
    jtag(0, jdo_a(a, 1'b0));
    m_areg = a;
    check("jtag_load_areg", 32'(mon_a), 32'(m_areg));
  endtask

  task automatic j_write(input logic [31:0] data);
    jtag(2, jdo_b(data));
    m_mem[m_areg] = data;
    m_areg = m_areg + 1'b1;
    check("jtag_write_areg", 32'(mon_a), 32'(m_areg));
  endtask

  // Read via Cmd A (kind 0) or Cmd N (kind 1); result due three cycles after the pulse.
  task automatic j_read(input int kind, input logic [AW-1:0] a);
    logic [31:0] old;
    old = m_dreg;
    if (kind == 0) begin
      jtag(0, jdo_a(a, 1'b1));
      m_areg = a;
    end else begin
      jtag(1, '0);
    end
    m_dreg = m_mem[m_areg];
    m_areg = m_areg + 1'b1;
    tick();
    check("jtag_read_early", mon_d, old);
    tick();
    check("jtag_read_dreg", mon_d, m_dreg);
    check("jtag_read_areg", 32'(mon_a), 32'(m_areg));
  endtask

  task automatic cpu_wait(output int waits);
    bit done;
    waits = 0;
    done  = 0;
    while (!done) begin
      @(negedge clk);
      if (!avl.waitrequest) done = 1;
      else begin
        waits++;
        if (waits > 100) begin
          n_tests++;
          n_fail++;
          $display("FAIL cpu_timeout: got %0d wait cycles expected completion", waits);
          done = 1;
        end
      end
    end
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [31:0] data,
                           input logic [3:0] be, input logic da, output int waits);
    avl.address = a; avl.writedata = data; avl.byteenable = be;
    avl.debugaccess = da; avl.write = 1'b1;
    cpu_wait(waits);
    if (da) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) m_mem[a][8*b +: 8] = data[8*b +: 8];
    end
    tick();
    avl.write = 1'b0;
  endtask

  task automatic cpu_read(input logic [AW-1:0] a, input logic da, output int waits);
    exp_q.push_back(da ? m_mem[a] : 32'd0);
    avl.address = a; avl.debugaccess = da; avl.read = 1'b1;
    cpu_wait(waits);
    tick();
    avl.read = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, wsum;
    logic [31:0] d1;
    logic [AW-1:0] x, ca;
    avl.address = '0; avl.read = 1'b0; avl.write = 1'b0;
    avl.writedata = '0; avl.byteenable = '0; avl.debugaccess = 1'b0;

    repeat (3) tick();
    reset = 1'b0;
    check("reset_mondreg", mon_d, 32'd0);
    check("reset_monareg", 32'(mon_a), 32'd0);
    check("reset_overrun", 32'(ovr), 32'd0);
    check("reset_readdata", avl.readdata, 32'd0);
    check("reset_waitreq", 32'(avl.waitrequest), 32'd0);

    // Fill the RAM through zero-wait CPU writes.
    wsum = 0;
    for (int i = 0; i < DEPTH; i++) begin
      cpu_write(AW'(i), $urandom, 4'hF, 1'b1, w);
      wsum += w;
    end
    check("fill_zero_wait", wsum, 32'd0);

    // JTAG write, read back, Cmd N, wrap.
    j_load(8'h10);
    j_write(32'hCAFEF00D);
    check("plan_areg_11", 32'(mon_a), 32'h11);
    j_read(0, 8'h10);
    check("plan_dreg_cafe", mon_d, 32'hCAFEF00D);
    j_read(1, '0);
    check("plan_areg_12", 32'(mon_a), 32'h12);
    j_load(8'hFF);
    j_write($urandom);
    check("plan_wrap", 32'(mon_a), 32'h0);

    // CPU byte-enable merge and debugaccess gating.
    cpu_write(8'h20, 32'hFFFFFFFF, 4'hF, 1'b1, w);
    cpu_write(8'h20, 32'h12345678, 4'b0011, 1'b1, w);
    check("cpu_write_waits", w, 32'd0);
    cpu_read(8'h20, 1'b1, w);
    check("cpu_read_waits", w, 32'd2);
    cpu_write(8'h20, 32'h0, 4'hF, 1'b0, w);
    cpu_read(8'h20, 1'b0, w);
    cpu_read(8'h20, 1'b1, w);

    // Overrun: three commands one cycle apart starting in J_RD, CPU read held throughout.
    x  = 8'h40;
    ca = 8'h80;
    d1 = $urandom;
    jtag(0, jdo_a(x, 1'b1));
    m_areg = x;
    m_dreg = m_mem[x];
    m_areg = m_areg + 1'b1;
    fork
      begin
        cpu_read(ca, 1'b1, w);
      end
      begin
        jtag(2, jdo_b(d1));
        m_mem[m_areg] = d1;
        m_areg = m_areg + 1'b1;
        jtag(2, jdo_b(~d1));
        m_ovr = 1'b1;
        check("ovr_first_read", mon_d, m_dreg);
        check("ovr_flag", 32'(ovr), 32'(m_ovr));
        jtag(1, '0);
        m_dreg = m_mem[m_areg];
        m_areg = m_areg + 1'b1;
      end
    join
    check("ovr_cpu_stall", w, 32'd8);
    check("ovr_final_dreg", mon_d, m_dreg);
    check("ovr_final_areg", 32'(mon_a), 32'(m_areg));
    check("ovr_sticky", 32'(ovr), 32'(m_ovr));
    cpu_read(x + 8'd1, 1'b1, w);

    // Randomised mix checked against the model.
    for (int i = 0; i < 150; i++) begin
      int op;
      logic [AW-1:0] a;
      logic [31:0] data;
      op = $urandom_range(0, 4);
      a = AW'($urandom);
      data = $urandom;
      case (op)
        0: begin j_load(a); j_write(data); end
        1: j_read(0, a);
        2: j_read(1, '0);
        3: begin
          cpu_write(a, data, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), w);
          check("rand_cpu_write_waits", w, 32'd0);
        end
        default: begin
          cpu_read(a, ($urandom_range(0, 3) != 0), w);
          check("rand_cpu_read_waits", w, 32'd2);
        end
      endcase
    end

    // Reset while in J_RD: read abandoned, registers cleared, RAM kept.
    jtag(0, jdo_a(8'h33, 1'b1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_areg = '0;
    m_dreg = '0;
    m_ovr  = 1'b0;
    check("rst_mondreg", mon_d, m_dreg);
    check("rst_monareg", 32'(mon_a), 32'(m_areg));
    check("rst_overrun", 32'(ovr), 32'(m_ovr));
    tick();
    tick();
    check("rst_no_late_dreg", mon_d, m_dreg);
    cpu_read(8'h33, 1'b1, w);
    check("rst_cpu_read_waits", w, 32'd2);

    tick();
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
